// File: rtl/accel_pkg.sv
// Shared types and register map for the accelerometer SPI sequencer.
// State encoding, device registers, config values and tx word packing.
package accel_pkg;

  typedef enum logic [3:0] {
    ST_BOOT      = 4'd0,
    ST_ID_ISSUE  = 4'd1,
    ST_ID_WAIT   = 4'd2,
    ST_CFG_ISSUE = 4'd3,
    ST_CFG_WAIT  = 4'd4,
    ST_POLL_WAIT = 4'd5,
    ST_RD_ISSUE  = 4'd6,
    ST_RD_WAIT   = 4'd7,
    ST_PUBLISH   = 4'd8
  } state_t;

  localparam logic [5:0] REG_DEVID       = 6'h00;
  localparam logic [5:0] REG_BW_RATE     = 6'h2C;
  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0      = 6'h32;

  localparam logic [7:0] VAL_DATA_FORMAT = 8'h0B;
  localparam logic [7:0] VAL_BW_RATE     = 8'h0A;
  localparam logic [7:0] VAL_POWER_CTL   = 8'h08;

  localparam logic [7:0] DEVID_EXPECTED  = 8'hE5;

  localparam logic [2:0] CFG_LAST = 3'd2;
  localparam logic [2:0] RD_LAST  = 3'd5;

  function automatic logic [15:0] tx_word(
    input logic       rd,
    input logic [5:0] addr,
    input logic [7:0] data
  );
    return {rd, 1'b0, addr, data};
  endfunction

endpackage

// File: rtl/accel_spi_sequencer.sv
// Accelerometer SPI sequencer: ID check, three config writes,
// then periodic six-byte axis polls published as signed X/Y/Z.
module accel_spi_sequencer
  import accel_pkg::*;
#(
  parameter int SAMPLE_DIV   = 50000,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic        spi_clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  input  logic [7:0]  rx_data,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        id_error,
  output logic        timeout_error
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(DONE_TIMEOUT - 1);

  state_t        state;
  logic [2:0]    idx;
  logic [TW-1:0] timer;
  logic [CW-1:0] to_cnt;
  logic [7:0]    rbuf [0:4];

  logic [5:0]    cfg_addr;
  logic [7:0]    cfg_val;
  logic          to_hit;

  assign to_hit = (to_cnt == TO_LAST);

  always_comb begin
    cfg_addr = REG_DATA_FORMAT;
    cfg_val  = VAL_DATA_FORMAT;
    case (idx)
      3'd1: begin
        cfg_addr = REG_BW_RATE;
        cfg_val  = VAL_BW_RATE;
      end
      3'd2: begin
        cfg_addr = REG_POWER_CTL;
        cfg_val  = VAL_POWER_CTL;
      end
      default: ;
    endcase
  end

  // Word stays stable from ISSUE through the matching WAIT.
  always_comb begin
    tx_data  = '0;
    tx_start = 1'b0;
    unique case (state)
      ST_ID_ISSUE, ST_ID_WAIT:
        tx_data = tx_word(1'b1, REG_DEVID, 8'h00);
      ST_CFG_ISSUE, ST_CFG_WAIT:
        tx_data = tx_word(1'b0, cfg_addr, cfg_val);
      ST_RD_ISSUE, ST_RD_WAIT:
        tx_data = tx_word(1'b1, REG_DATAX0 + {3'b000, idx}, 8'h00);
      default: ;
    endcase
    tx_start = enable &&
      (state == ST_ID_ISSUE || state == ST_CFG_ISSUE ||
       state == ST_RD_ISSUE);
  end

  always_ff @(posedge spi_clk) begin
    if (reset) begin
      state         <= ST_BOOT;
      idx           <= '0;
      timer         <= '0;
      to_cnt        <= '0;
      init_done     <= 1'b0;
      id_error      <= 1'b0;
      timeout_error <= 1'b0;
      sample_valid  <= 1'b0;
      accel_x       <= '0;
      accel_y       <= '0;
      accel_z       <= '0;
      for (int i = 0; i < 5; i++) rbuf[i] <= '0;
    end else begin
      timer        <= (timer == T_LAST) ? '0 : timer + 1'b1;
      sample_valid <= 1'b0;
      unique case (state)
        ST_BOOT: begin
          idx <= '0;
          if (enable) state <= ST_ID_ISSUE;
        end
        ST_ID_ISSUE: begin
          if (enable) begin
            state  <= ST_ID_WAIT;
            to_cnt <= CW'(1);
          end
        end
        ST_ID_WAIT: begin
          if (tx_done) begin
            id_error <= id_error | (rx_data != DEVID_EXPECTED);
            idx      <= '0;
            state    <= ST_CFG_ISSUE;
          end else if (to_hit) begin
            timeout_error <= 1'b1;
            state         <= ST_ID_ISSUE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_CFG_ISSUE: begin
          if (enable) begin
            state  <= ST_CFG_WAIT;
            to_cnt <= CW'(1);
          end
        end
        ST_CFG_WAIT: begin
          if (tx_done) begin
            if (idx == CFG_LAST) begin
              init_done <= 1'b1;
              state     <= ST_POLL_WAIT;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_CFG_ISSUE;
            end
          end else if (to_hit) begin
            timeout_error <= 1'b1;
            idx           <= '0;
            state         <= ST_ID_ISSUE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_POLL_WAIT: begin
          if (enable && timer == T_LAST) begin
            idx   <= '0;
            state <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: begin
          if (enable) begin
            state  <= ST_RD_WAIT;
            to_cnt <= CW'(1);
          end
        end
        ST_RD_WAIT: begin
          if (tx_done) begin
            // Last byte bypasses the buffer so PUBLISH shows the sample.
            if (idx == RD_LAST) begin
              accel_x      <= {rbuf[1], rbuf[0]};
              accel_y      <= {rbuf[3], rbuf[2]};
              accel_z      <= {rx_data, rbuf[4]};
              sample_valid <= 1'b1;
              state        <= ST_PUBLISH;
            end else begin
              rbuf[idx] <= rx_data;
              idx       <= idx + 1'b1;
              state     <= ST_RD_ISSUE;
            end
          end else if (to_hit) begin
            timeout_error <= 1'b1;
            timer         <= '0;
            state         <= ST_POLL_WAIT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_PUBLISH: begin
          timer <= '0;
          state <= ST_POLL_WAIT;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Bench for accel_spi_sequencer with a behavioural serializer and
// accelerometer register model driving tx_done/rx_data.
module tb_accel_spi_sequencer;

  localparam int SD = 300;
  localparam int DT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        tx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] tx_data;
  logic        tx_start;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, init_done, id_error, timeout_error;

  always #5 clk = ~clk;

  accel_spi_sequencer #(.SAMPLE_DIV(SD), .DONE_TIMEOUT(DT)) dut (
    .spi_clk(clk), .reset(reset), .enable(enable),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .rx_data(rx_data), .accel_x(accel_x), .accel_y(accel_y),
    .accel_z(accel_z), .sample_valid(sample_valid),
    .init_done(init_done), .id_error(id_error),
    .timeout_error(timeout_error)
  );

  int total = 0;
  int bad = 0;

  logic [7:0]  mem [0:63];
  int          cyc = 0;
  int          done_at = -1;
  logic [15:0] pend_word = '0;
  logic        fail_armed = 1'b0;
  logic [15:0] fail_word = '0;

  logic [15:0] tx_words [$];
  int          tx_cycles [$];
  int          sv_cycles [$];
  logic [15:0] sv_x [$], sv_y [$], sv_z [$];
  int          init_cyc = -1;
  int          to_cyc = -1;
  int          start_in_done = 0;
  int          held_err = 0;

  // Serializer: tx_start in cycle k gives tx_done in cycle k+18.
  always @(posedge clk) begin
    cyc++;
    #1;
    tx_done = (done_at == cyc);
    if (tx_done)
      rx_data = pend_word[15] ? mem[pend_word[13:8]] : 8'h00;
    else
      rx_data = 8'($urandom);
  end

  always @(negedge clk) begin
    if (reset) begin
      done_at = -1;
    end else begin
      if (done_at >= cyc && tx_data !== pend_word) held_err++;
      if (tx_start) begin
        tx_words.push_back(tx_data);
        tx_cycles.push_back(cyc);
        if (tx_done) start_in_done++;
        if (fail_armed && tx_data == fail_word) begin
          fail_armed = 1'b0;
        end else begin
          done_at   = cyc + 18;
          pend_word = tx_data;
        end
      end
      if (sample_valid) begin
        sv_cycles.push_back(cyc);
        sv_x.push_back(accel_x);
        sv_y.push_back(accel_y);
        sv_z.push_back(accel_z);
      end
      if (init_done && init_cyc < 0) init_cyc = cyc;
      if (timeout_error && to_cyc < 0) to_cyc = cyc;
    end
  end

  function automatic int axis(input int lo);
    int v;
    v = int'(mem[lo + 1]) * 256 + int'(mem[lo]);
    if (v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic logic [15:0] rd_word(input int i);
    return 16'(32'h8000 + (32'h32 + i) * 256);
  endfunction

  task automatic clear_logs();
    tx_words.delete(); tx_cycles.delete(); sv_cycles.delete();
    sv_x.delete(); sv_y.delete(); sv_z.delete();
    init_cyc = -1; to_cyc = -1;
    start_in_done = 0; held_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; done_at = -1; fail_armed = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic wait_sv(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      ok = (sv_cycles.size() > n);
    end
  endtask

  task automatic wait_init(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk);
      ok = (init_cyc >= 0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({tx_start, tx_data, sample_valid} !== 18'd0) begin
      bad++;
      $display("FAIL reset_tx got start=%b data=%h want 0 0",
               tx_start, tx_data);
    end
    total++;
    if ({accel_x, accel_y, accel_z} !== 48'd0) begin
      bad++;
      $display("FAIL reset_axes got %h %h %h want 0",
               accel_x, accel_y, accel_z);
    end
    total++;
    if ({init_done, id_error, timeout_error} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got %b want 000",
               {init_done, id_error, timeout_error});
    end
    reset = 1'b0;
    clear_logs();
    repeat (20) @(negedge clk);
    total++;
    if (tx_words.size() != 0) begin
      bad++;
      $display("FAIL boot_hold got %0d starts want 0", tx_words.size());
    end
  endtask

  task automatic test_init();
    bit ok;
    logic [15:0] exp [4];
    exp = '{16'h8000, 16'h310B, 16'h2C0A, 16'h2D08};
    enable = 1'b1;
    wait_init(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL init_wait got no init_done want within 500");
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tx_words[i] !== exp[i]) begin
        bad++;
        $display("FAIL init_word%0d got %h want %h", i, tx_words[i], exp[i]);
      end
    end
    total++;
    if (init_cyc - tx_cycles[0] != 76) begin
      bad++;
      $display("FAIL init_latency got %0d want 76", init_cyc - tx_cycles[0]);
    end
    total++;
    if (id_error !== 1'b0 || timeout_error !== 1'b0) begin
      bad++;
      $display("FAIL init_errs got id=%b to=%b want 0 0",
               id_error, timeout_error);
    end
  endtask

  task automatic test_poll_fixed();
    bit ok;
    int n, b;
    wait_sv(0, 2 * SD + 300, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL poll_wait got no sample_valid want one");
    end
    n = tx_words.size();
    b = n - 6;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (tx_words[b + i] !== rd_word(i)) begin
        bad++;
        $display("FAIL poll_addr%0d got %h want %h",
                 i, tx_words[b + i], rd_word(i));
      end
    end
    total++;
    if (sv_cycles[$] - tx_cycles[b] != 114) begin
      bad++;
      $display("FAIL poll_latency got %0d want 114",
               sv_cycles[$] - tx_cycles[b]);
    end
    total++;
    if (sv_x[$] !== 16'h1234 || int'($signed(sv_y[$])) != -1 ||
        int'($signed(sv_z[$])) != -32768) begin
      bad++;
      $display("FAIL poll_fixed got %h %h %h want 1234 ffff 8000",
               sv_x[$], sv_y[$], sv_z[$]);
    end
    @(negedge clk);
    total++;
    if (sample_valid !== 1'b0 || sv_cycles.size() != 1) begin
      bad++;
      $display("FAIL poll_pulse got sv=%b count=%0d want 0 1",
               sample_valid, sv_cycles.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n, prev, b;
    for (int r = 0; r < 3; r++) begin
      for (int a = 8'h32; a <= 8'h37; a++) mem[a] = 8'($urandom);
      if (r == 1) begin
        mem[8'h33] = 8'h7F; mem[8'h32] = 8'hFF;
      end
      n = sv_cycles.size();
      prev = sv_cycles[$];
      wait_sv(n, SD + 300, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL b2b%0d_wait got none want sample", r);
      end
      b = tx_cycles.size() - 6;
      total++;
      if (tx_cycles[b] - prev != SD + 1) begin
        bad++;
        $display("FAIL b2b%0d_gap got %0d want %0d",
                 r, tx_cycles[b] - prev, SD + 1);
      end
      total++;
      if (int'($signed(sv_x[$])) != axis(8'h32) ||
          int'($signed(sv_y[$])) != axis(8'h34) ||
          int'($signed(sv_z[$])) != axis(8'h36)) begin
        bad++;
        $display("FAIL b2b%0d_axes got %h %h %h want %0d %0d %0d", r,
                 sv_x[$], sv_y[$], sv_z[$],
                 axis(8'h32), axis(8'h34), axis(8'h36));
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n, b;
    logic [15:0] px, py, pz;
    px = accel_x; py = accel_y; pz = accel_z;
    n = sv_cycles.size();
    total++;
    if (timeout_error !== 1'b0) begin
      bad++;
      $display("FAIL to_pre got %b want 0", timeout_error);
    end
    fail_word = 16'hB400;
    fail_armed = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2 * SD + 300 && !ok; i++) begin
      @(posedge clk);
      ok = (to_cyc >= 0);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL to_wait got no timeout_error want one");
    end
    total++;
    if (tx_words[$] !== 16'hB400 || to_cyc - tx_cycles[$] != DT) begin
      bad++;
      $display("FAIL to_latency got word=%h dt=%0d want b400 %0d",
               tx_words[$], to_cyc - tx_cycles[$], DT);
    end
    @(negedge clk);
    total++;
    if (sv_cycles.size() != n || accel_x !== px ||
        accel_y !== py || accel_z !== pz) begin
      bad++;
      $display("FAIL to_abandon got cnt=%0d x=%h want %0d %h",
               sv_cycles.size(), accel_x, n, px);
    end
    for (int a = 8'h32; a <= 8'h37; a++) mem[a] = 8'($urandom);
    wait_sv(n, SD + 300, ok);
    b = tx_cycles.size() - 6;
    total++;
    if (!ok || tx_cycles[b] - to_cyc != SD) begin
      bad++;
      $display("FAIL to_resume got ok=%b gap=%0d want 1 %0d",
               ok, tx_cycles[b] - to_cyc, SD);
    end
    total++;
    if (int'($signed(sv_x[$])) != axis(8'h32) ||
        int'($signed(sv_z[$])) != axis(8'h36) || timeout_error !== 1'b1) begin
      bad++;
      $display("FAIL to_next got x=%h z=%h to=%b want %0d %0d 1",
               sv_x[$], sv_z[$], timeout_error, axis(8'h32), axis(8'h36));
    end
  endtask

  task automatic test_enable();
    bit ok;
    int n, m;
    @(negedge clk);
    enable = 1'b0;
    n = tx_words.size();
    m = sv_cycles.size();
    repeat (1000) @(negedge clk);
    total++;
    if (tx_words.size() != n || sv_cycles.size() != m) begin
      bad++;
      $display("FAIL en_hold got %0d starts want 0", tx_words.size() - n);
    end
    for (int a = 8'h32; a <= 8'h37; a++) mem[a] = 8'($urandom);
    enable = 1'b1;
    wait_sv(m, SD + 200, ok);
    total++;
    if (!ok || int'($signed(sv_y[$])) != axis(8'h34)) begin
      bad++;
      $display("FAIL en_resume got ok=%b y=%h want 1 %0d",
               ok, sv_y[$], axis(8'h34));
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * SD + 300 && !ok; i++) begin
      @(posedge clk);
      ok = (tx_words.size() > 0 && tx_words[$] == 16'hB300);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rm_wait got no b300 want one");
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    done_at = -1;
    @(negedge clk);
    total++;
    if ({accel_x, accel_y, accel_z, tx_data} !== 64'd0) begin
      bad++;
      $display("FAIL rm_data got %h %h %h %h want 0",
               accel_x, accel_y, accel_z, tx_data);
    end
    total++;
    if ({tx_start, sample_valid, init_done, id_error, timeout_error}
        !== 5'd0) begin
      bad++;
      $display("FAIL rm_flags got %b want 00000",
               {tx_start, sample_valid, init_done, id_error, timeout_error});
    end
    reset = 1'b0;
    clear_logs();
    wait_init(ok);
    total++;
    if (!ok || tx_words[0] !== 16'h8000 || init_cyc - tx_cycles[0] != 76) begin
      bad++;
      $display("FAIL rm_restart got ok=%b w=%h lat=%0d want 1 8000 76",
               ok, tx_words[0], init_cyc - tx_cycles[0]);
    end
  endtask

  task automatic test_id_error();
    bit ok;
    mem[0] = 8'h00;
    for (int a = 8'h32; a <= 8'h37; a++) mem[a] = 8'($urandom);
    do_reset();
    wait_init(ok);
    total++;
    if (!ok || id_error !== 1'b1) begin
      bad++;
      $display("FAIL id_flag got ok=%b id=%b want 1 1", ok, id_error);
    end
    total++;
    if (tx_words[1] !== 16'h310B || tx_words[2] !== 16'h2C0A ||
        tx_words[3] !== 16'h2D08) begin
      bad++;
      $display("FAIL id_cfg got %h %h %h want 310b 2c0a 2d08",
               tx_words[1], tx_words[2], tx_words[3]);
    end
    wait_sv(0, 2 * SD + 300, ok);
    total++;
    if (!ok || int'($signed(sv_x[$])) != axis(8'h32)) begin
      bad++;
      $display("FAIL id_poll got ok=%b x=%h want 1 %0d",
               ok, sv_x[$], axis(8'h32));
    end
    total++;
    if (start_in_done != 0 || held_err != 0) begin
      bad++;
      $display("FAIL handshake got overlap=%0d unheld=%0d want 0 0",
               start_in_done, held_err);
    end
    mem[0] = 8'hE5;
  endtask

  initial begin
    for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
    mem[0] = 8'hE5;
    mem[8'h32] = 8'h34; mem[8'h33] = 8'h12;
    mem[8'h34] = 8'hFF; mem[8'h35] = 8'hFF;
    mem[8'h36] = 8'h00; mem[8'h37] = 8'h80;
    test_reset();
    test_init();
    test_poll_fixed();
    test_back_to_back();
    test_timeout();
    test_enable();
    test_reset_mid();
    test_id_error();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish want finish by 1ms");
    $fatal(1);
  end

endmodule
